// File: rtl/watchdog_pkg.sv
// watchdog_pkg: shared types and constants for the watchdog timer
package watchdog_pkg;
    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        COUNTING = 2'd1,
        EXPIRED  = 2'd2
    } state_t;
    localparam int CNT_WIDTH = 32;
    localparam int DISABLE_TIMEOUT = 0;
endpackage

// File: rtl/watchdog_timer.sv
// watchdog_timer: cycle-counting watchdog raising a sticky system-reset request
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   kick_i     service pulse, each high cycle restarts the count
//   timeout_i  timeout in cycles, 0 disables
//   sys_rst_o  registered sticky reset request
module watchdog_timer
    import watchdog_pkg::*;
#(
    parameter int CntWidth = CNT_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                kick_i,
    input  logic [CntWidth-1:0] timeout_i,
    output logic                sys_rst_o
);
    state_t              state, state_n;
    logic [CntWidth-1:0] cnt, cnt_n;
    logic [CntWidth:0]   cnt_inc;
    logic                disabled;
    // one extra bit so an all-ones timeout never wraps the compare
    assign cnt_inc  = {1'b0, cnt} + (CntWidth+1)'(1);
    assign disabled = timeout_i == CntWidth'(DISABLE_TIMEOUT);
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state != EXPIRED) begin
            if (disabled) begin
                state_n = DISABLED;
                cnt_n   = '0;
            end else if (state == DISABLED || kick_i) begin
                state_n = COUNTING;
                cnt_n   = '0;
            end else if (cnt_inc >= {1'b0, timeout_i}) begin
                state_n = EXPIRED;
            end else begin
                cnt_n = cnt_inc[CntWidth-1:0];
            end
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= COUNTING;
            cnt       <= '0;
            sys_rst_o <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sys_rst_o <= state_n == EXPIRED;
        end
    end
endmodule

// File: tb/tb_watchdog_timer.sv
// tb_watchdog_timer: directed and randomized checks of the watchdog timer
module tb_watchdog_timer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        kick = 1'b0;
    logic [31:0] timeout = 32'd10;
    logic        sys_rst;
    int          checks = 0;
    int          errors = 0;
    bit          m_exp;
    bit          m_en;
    longint      m_since;

    watchdog_timer #(.CntWidth(32)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .kick_i(kick),
        .timeout_i(timeout),
        .sys_rst_o(sys_rst)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_exp = 0;
        m_en = 1;
        m_since = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic tick();
        bit     k;
        longint t;
        k = kick;
        t = longint'(timeout);
        @(posedge clk);
        #1;
        if (!m_exp) begin
            if (t == 0) begin
                m_en = 0;
                m_since = 0;
            end else if (!m_en || k) begin
                m_en = 1;
                m_since = 0;
            end else if (m_since + 1 >= t) m_exp = 1;
            else m_since = m_since + 1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checks++;
        if (sys_rst !== 1'b0) begin
            errors++;
            $display("FAIL reset_value: sys_rst=%b expected 0", sys_rst);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_no_kick();
        apply_reset();
        kick = 0;
        timeout = 10;
        for (int i = 1; i <= 30; i++) begin
            tick();
            checks++;
            if (sys_rst !== (i >= 10)) begin
                errors++;
                $display("FAIL no_kick edge %0d: sys_rst=%b expected %b", i, sys_rst, i >= 10);
            end
        end
    endtask

    task automatic test_kick_once();
        apply_reset();
        timeout = 10;
        for (int i = 1; i <= 20; i++) begin
            kick = (i == 5);
            tick();
            checks++;
            if (sys_rst !== (i >= 15)) begin
                errors++;
                $display("FAIL kick_once edge %0d: sys_rst=%b expected %b", i, sys_rst, i >= 15);
            end
        end
        kick = 0;
        apply_reset();
        for (int i = 1; i <= 100; i++) begin
            kick = (i % 8 == 0);
            tick();
            checks++;
            if (sys_rst !== 1'b0) begin
                errors++;
                $display("FAIL periodic_kick edge %0d: sys_rst=%b expected 0", i, sys_rst);
            end
        end
        kick = 0;
    endtask

    task automatic test_kick_on_expiry();
        apply_reset();
        timeout = 10;
        for (int i = 1; i <= 22; i++) begin
            kick = (i == 10);
            tick();
            checks++;
            if (sys_rst !== (i >= 20)) begin
                errors++;
                $display("FAIL kick_on_expiry edge %0d: sys_rst=%b expected %b", i, sys_rst, i >= 20);
            end
        end
        kick = 0;
    endtask

    task automatic test_disable();
        apply_reset();
        timeout = 0;
        for (int i = 1; i <= 50; i++) begin
            kick = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (sys_rst !== 1'b0) begin
                errors++;
                $display("FAIL disabled edge %0d: sys_rst=%b expected 0", i, sys_rst);
            end
        end
        kick = 0;
        timeout = 4;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (sys_rst !== (i >= 5)) begin
                errors++;
                $display("FAIL reenable edge %0d: sys_rst=%b expected %b", i, sys_rst, i >= 5);
            end
        end
    endtask

    task automatic test_sticky();
        apply_reset();
        timeout = 5;
        repeat (5) tick();
        checks++;
        if (sys_rst !== 1'b1) begin
            errors++;
            $display("FAIL sticky_expire: sys_rst=%b expected 1", sys_rst);
        end
        kick = 1;
        timeout = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (sys_rst !== 1'b1) begin
                errors++;
                $display("FAIL sticky_hold edge %0d: sys_rst=%b expected 1", i, sys_rst);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sys_rst !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: sys_rst=%b expected 0", sys_rst);
        end
        kick = 0;
        timeout = 5;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (sys_rst !== (i >= 5)) begin
                errors++;
                $display("FAIL restart edge %0d: sys_rst=%b expected %b", i, sys_rst, i >= 5);
            end
        end
    endtask

    task automatic test_lower_timeout();
        apply_reset();
        timeout = 100;
        repeat (50) tick();
        checks++;
        if (sys_rst !== 1'b0) begin
            errors++;
            $display("FAIL before_lower: sys_rst=%b expected 0", sys_rst);
        end
        timeout = 20;
        tick();
        checks++;
        if (sys_rst !== 1'b1) begin
            errors++;
            $display("FAIL lower_timeout: sys_rst=%b expected 1", sys_rst);
        end
        apply_reset();
        timeout = 32'hFFFF_FFFF;
        for (int i = 1; i <= 1000; i++) begin
            tick();
            checks++;
            if (sys_rst !== 1'b0) begin
                errors++;
                $display("FAIL max_timeout edge %0d: sys_rst=%b expected 0", i, sys_rst);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        timeout = 6;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                kick = 0;
                apply_reset();
            end
            kick = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) timeout = 32'($urandom_range(0, 12));
            tick();
            checks++;
            if (sys_rst !== m_exp) begin
                errors++;
                $display("FAIL random cycle %0d: sys_rst=%b expected %b", i, sys_rst, m_exp);
            end
        end
        kick = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_no_kick();
        test_kick_once();
        test_kick_on_expiry();
        test_disable();
        test_sticky();
        test_lower_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
